// File: rtl/fetch_mem_arbiter_pkg.sv
// Shared types and constants for the fetch-side memory read arbiter.
package fetch_mem_arbiter_pkg;

  // Requester slots on the shared read channel.
  localparam int REQ_ICACHE   = 0;
  localparam int REQ_DCACHE   = 1;
  localparam int REQ_UNCACHED = 2;

  // Default physical address / burst-length field widths.
  localparam int ADDR_W = 32;
  localparam int LEN_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
  } mem_read_req_t;

  // Width of an index into n requesters; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fetch_mem_arbiter_if.sv
// Requester-side handshake plus the AXI-style read channel, bundled.
// master = the arbiter; slave = requesters and the bus-side read master.
interface fetch_mem_arbiter_if #(
  parameter int NREQ       = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 4
);
  logic [NREQ-1:0]                 req_valid;
  logic [NREQ-1:0][ADDR_WIDTH-1:0] req_addr;
  logic [NREQ-1:0][LEN_WIDTH-1:0]  req_len;
  logic [NREQ-1:0]                 req_ready;
  logic [NREQ-1:0]                 resp_valid;
  logic [NREQ-1:0]                 resp_last;
  logic [DATA_WIDTH-1:0]           resp_data;
  logic                            resp_err;
  logic                            ar_valid;
  logic                            ar_ready;
  logic [ADDR_WIDTH-1:0]           ar_addr;
  logic [LEN_WIDTH-1:0]            ar_len;
  logic                            r_valid;
  logic                            r_ready;
  logic [DATA_WIDTH-1:0]           r_data;
  logic                            r_last;
  logic [1:0]                      r_resp;
  logic                            proto_err;

  modport master (
    input  req_valid, req_addr, req_len, ar_ready, r_valid, r_data, r_last, r_resp,
    output req_ready, resp_valid, resp_last, resp_data, resp_err,
           ar_valid, ar_addr, ar_len, r_ready, proto_err
  );

  modport slave (
    output req_valid, req_addr, req_len, ar_ready, r_valid, r_data, r_last, r_resp,
    input  req_ready, resp_valid, resp_last, resp_data, resp_err,
           ar_valid, ar_addr, ar_len, r_ready, proto_err
  );
endinterface

// File: rtl/fetch_mem_arbiter_rr_arbiter.sv
// Combinational round-robin priority encoder: the first requester at or
// after ptr (wrapping) wins. Produces a one-hot grant and its index.
module rr_arbiter #(
  parameter int NREQ = 3,
  parameter int IDXW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            any
);
  int   k;
  logic found;

  // Scan NREQ slots starting at ptr; first asserted request takes the grant.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    k       = 0;
    for (int i = 0; i < NREQ; i++) begin
      k = int'(ptr) + i;
      if (k >= NREQ) k = k - NREQ;
      if (!found && req[k]) begin
        found    = 1'b1;
        gnt[k]   = 1'b1;
        gnt_idx  = IDXW'(k);
      end
    end
    any = found;
  end
endmodule

// File: rtl/fetch_mem_arbiter.sv
// Shares one AXI-style read channel between I$ refill, D$ refill and the
// uncached read path. One burst in flight; beats routed to the owner with
// no added latency; a sticky flag records beat-count/r_last disagreement.
module fetch_mem_arbiter
  import fetch_mem_arbiter_pkg::*;
#(
  parameter int NREQ       = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                clk,
  input  logic                rst,
  fetch_mem_arbiter_if.master bus
);
  localparam int IDXW = idx_width(NREQ);

  arb_state_t            state_q, state_d;
  logic [IDXW-1:0]       rr_ptr, owner, gnt_idx;
  logic [NREQ-1:0]       gnt_oh;
  logic                  gnt_any;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  len_q, beat_cnt;
  logic                  proto_q;
  logic                  take, beat;

  logic [NREQ-1:0]       req_ready, resp_valid, resp_last;
  logic [DATA_WIDTH-1:0] resp_data;
  logic                  resp_err, ar_valid, r_ready;

  rr_arbiter #(.NREQ(NREQ), .IDXW(IDXW)) u_rr (
    .req     (bus.req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt_oh),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  // rst gates the grant so no acceptance pulse escapes while reset is held.
  assign take = (state_q == IDLE) && gnt_any && !rst;
  assign beat = (state_q == DATA) && bus.r_valid;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Burst latch, round-robin pointer, beat counter and sticky protocol flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= '0;
      owner    <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      beat_cnt <= '0;
      proto_q  <= 1'b0;
    end else begin
      if (take) begin
        owner    <= gnt_idx;
        addr_q   <= bus.req_addr[gnt_idx];
        len_q    <= bus.req_len[gnt_idx];
        beat_cnt <= '0;
        rr_ptr   <= (gnt_idx == IDXW'(NREQ-1)) ? '0 : gnt_idx + IDXW'(1);
      end
      if (beat) begin
        beat_cnt <= beat_cnt + LEN_WIDTH'(1);
        // Early r_last, or the expected final beat arriving without r_last.
        if (bus.r_last ? (beat_cnt != len_q) : (beat_cnt == len_q))
          proto_q <= 1'b1;
      end
    end
  end

  // Next state and handshake/routing outputs.
  always_comb begin
    state_d    = state_q;
    req_ready  = '0;
    resp_valid = '0;
    resp_last  = '0;
    resp_data  = '0;
    resp_err   = 1'b0;
    ar_valid   = 1'b0;
    r_ready    = 1'b0;
    case (state_q)
      IDLE: begin
        if (take) begin
          req_ready = gnt_oh;
          state_d   = ADDR;
        end
      end
      ADDR: begin
        ar_valid = 1'b1;
        if (bus.ar_ready) state_d = DATA;
      end
      DATA: begin
        r_ready   = 1'b1;
        resp_data = bus.r_data;
        if (bus.r_valid) begin
          resp_valid[owner] = 1'b1;
          resp_err          = (bus.r_resp != 2'b00);
          if (bus.r_last) begin
            resp_last[owner] = 1'b1;
            state_d          = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_last  = resp_last;
  assign bus.resp_data  = resp_data;
  assign bus.resp_err   = resp_err;
  assign bus.ar_valid   = ar_valid;
  assign bus.ar_addr    = addr_q;
  assign bus.ar_len     = len_q;
  assign bus.r_ready    = r_ready;
  assign bus.proto_err  = proto_q;
endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// Self-checking bench for fetch_mem_arbiter: directed scenarios plus a
// randomized loop scored against a round-robin / beat-count reference model.
module tb_fetch_mem_arbiter;
  import fetch_mem_arbiter_pkg::*;

  localparam int NREQ = 3;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int LW   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_mem_arbiter_if #(.NREQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus();

  fetch_mem_arbiter #(.NREQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int mptr     = 0;     // model round-robin pointer
  logic mproto = 1'b0;  // model sticky protocol error

  mem_read_req_t reqs [NREQ];

  // observations from the last burst
  logic [NREQ-1:0] obs_gnt;
  int              obs_gnt_cyc, obs_ar_cycles, obs_spurious;
  logic [AW-1:0]   obs_ar_addr;
  logic [LW-1:0]   obs_ar_len;
  logic [NREQ-1:0] obs_rv [$];
  logic [NREQ-1:0] obs_rl [$];
  logic [DW-1:0]   obs_rd [$];
  logic            obs_re [$];
  logic [DW-1:0]   sent   [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic apply_reqs();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i] = reqs[i].valid;
      bus.req_addr[i]  = reqs[i].addr;
      bus.req_len[i]   = reqs[i].len;
    end
  endtask

  // Round-robin rule: first set bit at or after the pointer, wrapping.
  function automatic int model_grant(input logic [NREQ-1:0] mask);
    for (int j = 0; j < NREQ; j++)
      if (mask[(mptr + j) % NREQ]) return (mptr + j) % NREQ;
    return -1;
  endfunction

  // Bus-side responder. Entered at posedge+1 of an IDLE cycle with requests
  // already applied; records what the arbiter presents, returns at posedge+1
  // after the final beat.
  task automatic serve_burst(input int ar_delay, input int nbeats, input int last_idx,
                             input int gapmax, input int err_idx, input logic [1:0] err_code);
    int gap;
    #1;
    obs_gnt = bus.req_ready;
    obs_gnt_cyc = cyc;
    @(posedge clk); #1;
    obs_ar_cycles = 0;
    for (int k = 0; k <= ar_delay; k++) begin
      bus.ar_ready = (k == ar_delay);
      #1;
      if (bus.ar_valid) obs_ar_cycles++;
      obs_ar_addr = bus.ar_addr;
      obs_ar_len  = bus.ar_len;
      @(posedge clk); #1;
    end
    bus.ar_ready = 1'b0;
    obs_rv.delete(); obs_rl.delete(); obs_rd.delete(); obs_re.delete(); sent.delete();
    obs_spurious = 0;
    for (int b = 0; b < nbeats; b++) begin
      gap = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
      for (int g = 0; g < gap; g++) begin
        bus.r_valid = 1'b0;
        #1;
        if (bus.resp_valid != '0 || bus.resp_last != '0 || !bus.r_ready) obs_spurious++;
        @(posedge clk); #1;
      end
      bus.r_valid = 1'b1;
      bus.r_data  = $urandom;
      bus.r_last  = (b == last_idx);
      bus.r_resp  = (b == err_idx) ? err_code : 2'b00;
      #1;
      obs_rv.push_back(bus.resp_valid);
      obs_rl.push_back(bus.resp_last);
      obs_rd.push_back(bus.resp_data);
      obs_re.push_back(bus.resp_err);
      sent.push_back(bus.r_data);
      if (!bus.r_ready) obs_spurious++;
      @(posedge clk); #1;
    end
    bus.r_valid = 1'b0;
    bus.r_last  = 1'b0;
    bus.r_resp  = 2'b00;
  endtask

  task automatic test_reset();
    for (int i = 0; i < NREQ; i++) reqs[i] = '{valid: 1'b1, addr: 32'h100 * i, len: 4'd0};
    apply_reqs();
    #12;
    n_checks++;
    if (bus.req_ready !== '0 || bus.ar_valid !== 1'b0 || bus.r_ready !== 1'b0)
      $display("FAIL reset_handshake req_ready=%b ar_valid=%b r_ready=%b exp 0", bus.req_ready, bus.ar_valid, bus.r_ready);
    else n_pass++;
    n_checks++;
    if (bus.resp_valid !== '0 || bus.resp_last !== '0 || bus.resp_err !== 1'b0 || bus.proto_err !== 1'b0)
      $display("FAIL reset_resp resp_valid=%b resp_last=%b err=%b proto=%b exp 0", bus.resp_valid, bus.resp_last, bus.resp_err, bus.proto_err);
    else n_pass++;
    n_checks++;
    if (bus.ar_addr !== '0 || bus.ar_len !== '0 || bus.resp_data !== '0)
      $display("FAIL reset_data ar_addr=%h ar_len=%0d resp_data=%h exp 0", bus.ar_addr, bus.ar_len, bus.resp_data);
    else n_pass++;
    for (int i = 0; i < NREQ; i++) reqs[i].valid = 1'b0;
    apply_reqs();
    @(posedge clk); #1;
    rst = 1'b0; mptr = 0; mproto = 1'b0;
  endtask

  task automatic test_round_robin();
    int eg, prev_cyc;
    for (int i = 0; i < NREQ; i++) reqs[i] = '{valid: 1'b1, addr: 32'h40 + 32'h100 * i, len: 4'd0};
    apply_reqs();
    prev_cyc = 0;
    for (int n = 0; n < 4; n++) begin
      eg = model_grant(3'b111);
      serve_burst(0, 1, 0, 0, -1, 2'b00);
      n_checks++;
      if (obs_gnt !== NREQ'(1 << eg)) $display("FAIL rr_grant%0d got %b exp %b", n, obs_gnt, NREQ'(1 << eg));
      else n_pass++;
      n_checks++;
      if (obs_ar_addr !== reqs[eg].addr || obs_ar_len !== 4'd0)
        $display("FAIL rr_ar%0d addr=%h len=%0d exp %h/0", n, obs_ar_addr, obs_ar_len, reqs[eg].addr);
      else n_pass++;
      n_checks++;
      if (obs_rv[0] !== NREQ'(1 << eg) || obs_rl[0] !== NREQ'(1 << eg))
        $display("FAIL rr_beat%0d rv=%b rl=%b exp %b", n, obs_rv[0], obs_rl[0], NREQ'(1 << eg));
      else n_pass++;
      if (n > 0) begin
        n_checks++;
        if (obs_gnt_cyc - prev_cyc !== 3) $display("FAIL rr_spacing%0d got %0d exp 3", n, obs_gnt_cyc - prev_cyc);
        else n_pass++;
      end
      prev_cyc = obs_gnt_cyc;
      mptr = (eg + 1) % NREQ;
    end
    for (int i = 0; i < NREQ; i++) reqs[i].valid = 1'b0;
    apply_reqs();
  endtask

  task automatic test_single_refill();
    reqs[REQ_ICACHE] = '{valid: 1'b1, addr: 32'h0000_1000, len: 4'd7};
    apply_reqs();
    serve_burst(2, 8, 7, 0, -1, 2'b00);
    mptr = (REQ_ICACHE + 1) % NREQ;
    reqs[REQ_ICACHE].valid = 1'b0;
    apply_reqs();
    n_checks++;
    if (obs_gnt !== 3'b001) $display("FAIL refill_grant got %b exp 001", obs_gnt);
    else n_pass++;
    n_checks++;
    if (obs_ar_cycles !== 3 || obs_ar_len !== 4'd7 || obs_ar_addr !== 32'h0000_1000)
      $display("FAIL refill_ar cycles=%0d len=%0d addr=%h exp 3/7/00001000", obs_ar_cycles, obs_ar_len, obs_ar_addr);
    else n_pass++;
    for (int b = 0; b < 8; b++) begin
      n_checks++;
      if (obs_rv[b] !== 3'b001 || obs_rl[b] !== ((b == 7) ? 3'b001 : 3'b000) || obs_rd[b] !== sent[b])
        $display("FAIL refill_beat%0d rv=%b rl=%b data=%h exp 001/%b/%h", b, obs_rv[b], obs_rl[b], obs_rd[b],
                 (b == 7) ? 3'b001 : 3'b000, sent[b]);
      else n_pass++;
    end
    n_checks++;
    if (bus.proto_err !== mproto) $display("FAIL refill_proto got %b exp %b", bus.proto_err, mproto);
    else n_pass++;
  endtask

  task automatic test_uncached_err();
    reqs[REQ_UNCACHED] = '{valid: 1'b1, addr: 32'hF000_0004, len: 4'd0};
    apply_reqs();
    serve_burst(1, 1, 0, 0, 0, 2'b10);
    mptr = (REQ_UNCACHED + 1) % NREQ;
    reqs[REQ_UNCACHED].valid = 1'b0;
    apply_reqs();
    n_checks++;
    if (obs_rv[0] !== 3'b100 || obs_rl[0] !== 3'b100 || obs_re[0] !== 1'b1)
      $display("FAIL uncached_beat rv=%b rl=%b err=%b exp 100/100/1", obs_rv[0], obs_rl[0], obs_re[0]);
    else n_pass++;
    #1;
    n_checks++;
    if (bus.ar_valid !== 1'b0 || bus.r_ready !== 1'b0)
      $display("FAIL uncached_idle ar_valid=%b r_ready=%b exp 0/0", bus.ar_valid, bus.r_ready);
    else n_pass++;
  endtask

  task automatic test_rvalid_gaps();
    reqs[REQ_DCACHE] = '{valid: 1'b1, addr: 32'h0000_2200, len: 4'd3};
    apply_reqs();
    serve_burst(1, 4, 3, 4, -1, 2'b00);
    mptr = (REQ_DCACHE + 1) % NREQ;
    reqs[REQ_DCACHE].valid = 1'b0;
    apply_reqs();
    n_checks++;
    if (obs_spurious !== 0) $display("FAIL gaps_spurious got %0d exp 0", obs_spurious);
    else n_pass++;
    for (int b = 0; b < 4; b++) begin
      n_checks++;
      if (obs_rv[b] !== 3'b010 || obs_rl[b] !== ((b == 3) ? 3'b010 : 3'b000) || obs_rd[b] !== sent[b])
        $display("FAIL gaps_beat%0d rv=%b rl=%b data=%h exp 010/%b/%h", b, obs_rv[b], obs_rl[b], obs_rd[b],
                 (b == 3) ? 3'b010 : 3'b000, sent[b]);
      else n_pass++;
    end
  endtask

  task automatic test_early_last();
    reqs[REQ_ICACHE] = '{valid: 1'b1, addr: 32'h0000_3000, len: 4'd7};
    apply_reqs();
    serve_burst(0, 3, 2, 0, -1, 2'b00);
    mptr = (REQ_ICACHE + 1) % NREQ;
    mproto = 1'b1;
    reqs[REQ_ICACHE].valid = 1'b0;
    apply_reqs();
    #1;
    n_checks++;
    if (bus.proto_err !== 1'b1 || bus.r_ready !== 1'b0)
      $display("FAIL early_last proto=%b r_ready=%b exp 1/0", bus.proto_err, bus.r_ready);
    else n_pass++;
    reqs[REQ_DCACHE] = '{valid: 1'b1, addr: 32'h0000_3400, len: 4'd1};
    apply_reqs();
    serve_burst(0, 2, 1, 0, -1, 2'b00);
    mptr = (REQ_DCACHE + 1) % NREQ;
    reqs[REQ_DCACHE].valid = 1'b0;
    apply_reqs();
    n_checks++;
    if (obs_gnt !== 3'b010 || obs_rv[1] !== 3'b010 || obs_rl[1] !== 3'b010 || obs_rd[1] !== sent[1])
      $display("FAIL early_next gnt=%b rv=%b rl=%b data=%h exp 010/010/010/%h", obs_gnt, obs_rv[1], obs_rl[1], obs_rd[1], sent[1]);
    else n_pass++;
    n_checks++;
    if (bus.proto_err !== 1'b1) $display("FAIL early_sticky proto=%b exp 1", bus.proto_err);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    reqs[REQ_ICACHE] = '{valid: 1'b1, addr: 32'h0000_5000, len: 4'd7};
    apply_reqs();
    serve_burst(0, 4, -1, 0, -1, 2'b00);
    reqs[REQ_ICACHE].valid = 1'b0;
    apply_reqs();
    bus.r_valid = 1'b1;
    bus.r_data  = 32'hDEAD_BEEF;
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.resp_valid !== '0 || bus.resp_last !== '0 || bus.resp_data !== '0 || bus.r_ready !== 1'b0)
      $display("FAIL arst_resp rv=%b rl=%b data=%h r_ready=%b exp 0", bus.resp_valid, bus.resp_last, bus.resp_data, bus.r_ready);
    else n_pass++;
    n_checks++;
    if (bus.proto_err !== 1'b0 || bus.ar_valid !== 1'b0 || bus.ar_addr !== '0 || bus.ar_len !== '0)
      $display("FAIL arst_ctrl proto=%b ar_valid=%b ar_addr=%h ar_len=%0d exp 0", bus.proto_err, bus.ar_valid, bus.ar_addr, bus.ar_len);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0; bus.r_valid = 1'b0;
    mptr = 0; mproto = 1'b0;
    for (int i = 0; i < NREQ; i++) reqs[i] = '{valid: 1'b1, addr: 32'h600 + 32'h10 * i, len: 4'd0};
    apply_reqs();
    serve_burst(0, 1, 0, 0, -1, 2'b00);
    mptr = 1;
    for (int i = 0; i < NREQ; i++) reqs[i].valid = 1'b0;
    apply_reqs();
    n_checks++;
    if (obs_gnt !== 3'b001 || obs_ar_addr !== 32'h600 || obs_rv[0] !== 3'b001 || obs_rl[0] !== 3'b001)
      $display("FAIL arst_regrant gnt=%b addr=%h rv=%b rl=%b exp 001/600/001/001", obs_gnt, obs_ar_addr, obs_rv[0], obs_rl[0]);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [NREQ-1:0] mask;
    int eg, nb, eidx;
    logic [1:0] ecode;
    for (int it = 0; it < 25; it++) begin
      mask = NREQ'($urandom_range(1, 7));
      for (int i = 0; i < NREQ; i++)
        reqs[i] = '{valid: mask[i], addr: $urandom, len: LW'($urandom_range(0, 7))};
      apply_reqs();
      eg = model_grant(mask);
      nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 10)) : int'(reqs[eg].len) + 1;
      eidx = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, nb - 1));
      ecode = 2'($urandom_range(1, 3));
      serve_burst(int'($urandom_range(0, 3)), nb, nb - 1, 2, eidx, ecode);
      mptr = (eg + 1) % NREQ;
      if (nb != int'(reqs[eg].len) + 1) mproto = 1'b1;
      n_checks++;
      if (obs_gnt !== NREQ'(1 << eg) || obs_ar_addr !== reqs[eg].addr || obs_ar_len !== reqs[eg].len)
        $display("FAIL rand%0d_grant gnt=%b addr=%h len=%0d exp %b/%h/%0d", it, obs_gnt, obs_ar_addr, obs_ar_len,
                 NREQ'(1 << eg), reqs[eg].addr, reqs[eg].len);
      else n_pass++;
      for (int b = 0; b < nb; b++) begin
        n_checks++;
        if (obs_rv[b] !== NREQ'(1 << eg) || obs_rl[b] !== ((b == nb - 1) ? NREQ'(1 << eg) : '0) ||
            obs_rd[b] !== sent[b] || obs_re[b] !== (b == eidx))
          $display("FAIL rand%0d_beat%0d rv=%b rl=%b data=%h err=%b exp owner %0d data %h err %b", it, b,
                   obs_rv[b], obs_rl[b], obs_rd[b], obs_re[b], eg, sent[b], (b == eidx));
        else n_pass++;
      end
      n_checks++;
      if (obs_spurious !== 0 || bus.proto_err !== mproto)
        $display("FAIL rand%0d_proto spurious=%0d proto=%b exp 0/%b", it, obs_spurious, bus.proto_err, mproto);
      else n_pass++;
    end
    for (int i = 0; i < NREQ; i++) reqs[i].valid = 1'b0;
    apply_reqs();
  endtask

  initial begin
    bus.req_valid = '0; bus.req_addr = '0; bus.req_len = '0;
    bus.ar_ready = 1'b0; bus.r_valid = 1'b0; bus.r_data = '0;
    bus.r_last = 1'b0; bus.r_resp = 2'b00;
    test_reset();
    test_round_robin();
    test_single_refill();
    test_uncached_err();
    test_rvalid_gaps();
    test_early_last();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/fetch_mem_arbiter.md
Name: fetch_mem_arbiter

Overview:
- Shares the single AXI-style read channel of the bus interface among the I$ line-refill engine, the D$ line-refill engine and the uncached (I/D) single-word read path.
- Sequences one burst at a time and routes the returned beats to the requester that owns the burst.
- Sits between the cache refill FSMs and the AXI read master, beside the fetch pipeline.

Parameters:
- NREQ, 3, number of requesters: 0 = I$ refill, 1 = D$ refill, 2 = uncached.
- ADDR_WIDTH, 32, width of the physical address.
- DATA_WIDTH, 32, width of one beat.
- LEN_WIDTH, 4, width of the burst-length field; beats per burst = len + 1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: asynchronous, active-high.
- req_valid  in  NREQ  request pending; requester holds it and its addr/len stable until req_ready.
- req_addr  in  NREQ*ADDR_WIDTH  per-requester start address.
- req_len  in  NREQ*LEN_WIDTH  per-requester beats-1.
- req_ready  out  NREQ  one-cycle acceptance pulse (one-hot).
- resp_valid  out  NREQ  beat valid for the owning requester (one-hot).
- resp_last  out  NREQ  final beat of the owner's burst.
- resp_data  out  DATA_WIDTH  beat data, shared by all requesters.
- resp_err  out  1  r_resp error on the current beat.
- ar_valid  out  1  address valid.
- ar_ready  in  1  address accepted.
- ar_addr  out  ADDR_WIDTH  burst address.
- ar_len  out  LEN_WIDTH  burst length.
- r_valid  in  1  beat valid.
- r_ready  out  1  beat accepted.
- r_data  in  DATA_WIDTH  beat data.
- r_last  in  1  final beat.
- r_resp  in  2  beat response; nonzero means error.
- proto_err  out  1  sticky flag: beat-count mismatch.

Behaviour:
- Reset (async) values:
  - FSM = IDLE, rr_ptr = 0, beat_cnt = 0, owner = 0.
  - All outputs 0, including proto_err.
  - Reset mid-burst abandons the burst immediately; the bus side is reset by the same rst.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - If any req_valid, grant round-robin starting at index rst_ptr... i.e. starting at rr_ptr.
  - Lowest index at or after rr_ptr, wrapping modulo NREQ, wins.
  - In the same cycle: req_ready[g] = 1; latch owner = g, addr = req_addr[g], len = req_len[g]; beat_cnt = 0; go to ADDR.
  - rr_ptr <= (g+1) mod NREQ.
- ADDR:
  - ar_valid = 1 with the latched addr and len.
  - On ar_valid & ar_ready, go to DATA. ar_* stay stable while waiting.
- DATA:
  - r_ready = 1.
  - Each r_valid drives resp_valid[owner] = r_valid and resp_data = r_data combinationally; zero added latency.
  - resp_err = (r_resp != 0), qualified by r_valid.
  - beat_cnt increments per beat, wrapping at 2^LEN_WIDTH.
  - On r_valid & r_last: resp_last[owner] = 1, go to IDLE.
  - If beat_cnt != len when r_last arrives, set proto_err.
  - If beat_cnt == len and r_last = 0, set proto_err and keep routing beats until r_last.
- Request-to-ar_valid latency is 1 cycle.
- One IDLE bubble cycle always separates consecutive bursts; no overlapping bursts, only one outstanding.
- req_valid dropped before req_ready is legal; the request is simply ignored.
- Non-owning requesters never see req_ready, resp_valid or resp_last.
- resp_data may carry r_data at any time, but is meaningful only when resp_valid is set.
- Simultaneous requests are resolved by round-robin. Grants are fair: a continuously asserted request is granted within NREQ bursts.
- len = 0 means a single beat; resp_valid and resp_last assert in the same cycle.

Decomposition:
- Shared package:
  - Requester index constants: REQ_ICACHE = 0, REQ_DCACHE = 1, REQ_UNCACHED = 2.
  - Enum arb_state_t {IDLE, ADDR, DATA}.
  - Typedef mem_read_req_t {valid, addr, len}.
- One natural sub-module: rr_arbiter (combinational priority encoder taking req and rr_ptr, producing a one-hot grant and its index). The FSM, latches and counter stay in the top.

Test Plan:
- Single I$ refill, len = 7, ar_ready asserted 2 cycles after ar_valid:
  - req_ready[0] pulses in cycle 0; ar_valid from cycle 1 to 3 with ar_len = 7.
  - 8 resp_valid[0] beats; resp_last[0] only on the 8th.
- All three req_valid held, rr_ptr = 0, each request len = 0:
  - Grant order 0, 1, 2, 0.
  - Each grant separated by ADDR, DATA and one IDLE cycle.
- Uncached len = 0 with r_resp = 2'b10:
  - resp_valid[2], resp_last[2] and resp_err all high in the same cycle; return to IDLE.
- r_last on beat 3 of a len = 7 burst:
  - proto_err = 1 and stays 1; FSM back in IDLE.
  - A next request is still served.
- rst asserted asynchronously mid-DATA on beat 4:
  - All outputs 0 immediately, FSM in IDLE, rr_ptr = 0.
  - A fresh request after reset is granted normally.
- r_valid gaps of random length during a len = 3 burst:
  - Exactly 4 resp_valid pulses with data matching r_data in order; no spurious resp_last.
